// File: rtl/accel_tile_controller.sv
// Job sequencer for the systolic-array accelerator: fetches M/K/N from the parameter
// RAM, validates them, then issues SA_ROWS x SA_COLS output tiles through a start/done handshake.
module accel_tile_controller #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int PARAM_BASE = 0,
    parameter int RD_LAT     = 1,
    parameter int SA_ROWS    = 4,
    parameter int SA_COLS    = 4,
    parameter int MAX_DIM    = 4096
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              finish,
    output logic              error,
    output logic              param_cs,
    output logic              param_oe,
    output logic              param_we,
    output logic [ADDR_W-1:0] param_addr,
    input  logic [DATA_W-1:0] param_rdata,
    output logic [DATA_W-1:0] M,
    output logic [DATA_W-1:0] K,
    output logic [DATA_W-1:0] N,
    output logic              tile_start,
    output logic [DATA_W-1:0] tile_m_idx,
    output logic [DATA_W-1:0] tile_n_idx,
    output logic [DATA_W-1:0] tile_m_sz,
    output logic [DATA_W-1:0] tile_n_sz,
    input  logic              tile_done,
    output logic [DATA_W-1:0] tiles_done,
    output logic [6:0]        state
);

    typedef enum logic [6:0] {
        IDLE  = 7'b0000001,
        PARAM = 7'b0000010,
        CHECK = 7'b0000100,
        ISSUE = 7'b0001000,
        WAIT  = 7'b0010000,
        FIN   = 7'b0100000,
        ERR   = 7'b1000000
    } state_t;

    localparam int CNT_W = $clog2(RD_LAT + 4);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(RD_LAT + 2);
    localparam logic [CNT_W-1:0]  NUM_RDS  = CNT_W'(3);
    localparam logic [DATA_W-1:0] ROWS     = DATA_W'(SA_ROWS);
    localparam logic [DATA_W-1:0] COLS     = DATA_W'(SA_COLS);
    localparam logic [DATA_W-1:0] MAXD     = DATA_W'(MAX_DIM);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(PARAM_BASE);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               finish_q, finish_d;
    logic               error_q, error_d;
    logic               cs_q, cs_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  m_q, m_d, k_q, k_d, n_q, n_d;
    logic               tile_start_q, tile_start_d;
    logic [DATA_W-1:0]  m_idx_q, m_idx_d, n_idx_q, n_idx_d;
    logic [DATA_W-1:0]  m_sz_q, m_sz_d, n_sz_q, n_sz_d;
    logic [DATA_W-1:0]  tiles_done_q, tiles_done_d;
    logic [DATA_W-1:0]  m_rem, n_rem;
    logic               dims_bad, last_tile, reading;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        error_d      = error_q;
        m_d          = m_q;
        k_d          = k_q;
        n_d          = n_q;
        m_idx_d      = m_idx_q;
        n_idx_d      = n_idx_q;
        m_sz_d       = m_sz_q;
        n_sz_d       = n_sz_q;
        tiles_done_d = tiles_done_q;
        m_rem        = '0;
        n_rem        = '0;

        dims_bad  = (m_q == '0) || (k_q == '0) || (n_q == '0) ||
                    (m_q > MAXD) || (k_q > MAXD) || (n_q > MAXD);
        last_tile = (m_idx_q + ROWS >= m_q) && (n_idx_q + COLS >= n_q);

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d      = PARAM;
                        cnt_d        = '0;
                        error_d      = 1'b0;
                        tiles_done_d = '0;
                    end
                end
                PARAM: begin
                    cnt_d = cnt_q + 1'b1;
                    // Word i returns RD_LAT cycles after its read, i.e. at cnt = i + RD_LAT
                    if (cnt_q == CNT_W'(RD_LAT))     m_d = param_rdata;
                    if (cnt_q == CNT_W'(RD_LAT + 1)) k_d = param_rdata;
                    if (cnt_q == LAST_CNT) begin
                        n_d     = param_rdata;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    m_idx_d = '0;
                    n_idx_d = '0;
                    state_d = dims_bad ? ERR : ISSUE;
                end
                ISSUE: state_d = WAIT;
                WAIT: begin
                    if (tile_done) begin
                        tiles_done_d = tiles_done_q + 1'b1;
                        if (last_tile) begin
                            state_d = FIN;
                        end else begin
                            state_d = ISSUE;
                            if (n_idx_q + COLS >= n_q) begin
                                n_idx_d = '0;
                                m_idx_d = m_idx_q + ROWS;
                            end else begin
                                n_idx_d = n_idx_q + COLS;
                            end
                        end
                    end
                end
                FIN:     state_d = IDLE;
                ERR:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (state_d == ERR) error_d = 1'b1;

        if (state_d == ISSUE) begin
            m_rem  = m_d - m_idx_d;
            n_rem  = n_d - n_idx_d;
            m_sz_d = (m_rem > ROWS) ? ROWS : m_rem;
            n_sz_d = (n_rem > COLS) ? COLS : n_rem;
        end

        // Outputs are registered, so they are derived from the next state
        reading      = (state_d == PARAM) && (cnt_d < NUM_RDS);
        cs_d         = reading;
        addr_d       = reading ? (BASE + ADDR_W'(cnt_d)) : BASE;
        busy_d       = (state_d != IDLE);
        finish_d     = (state_d == FIN);
        tile_start_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
            error_q      <= 1'b0;
            cs_q         <= 1'b0;
            addr_q       <= BASE;
            m_q          <= '0;
            k_q          <= '0;
            n_q          <= '0;
            tile_start_q <= 1'b0;
            m_idx_q      <= '0;
            n_idx_q      <= '0;
            m_sz_q       <= '0;
            n_sz_q       <= '0;
            tiles_done_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
            error_q      <= error_d;
            cs_q         <= cs_d;
            addr_q       <= addr_d;
            m_q          <= m_d;
            k_q          <= k_d;
            n_q          <= n_d;
            tile_start_q <= tile_start_d;
            m_idx_q      <= m_idx_d;
            n_idx_q      <= n_idx_d;
            m_sz_q       <= m_sz_d;
            n_sz_q       <= n_sz_d;
            tiles_done_q <= tiles_done_d;
        end
    end

    assign state      = state_q;
    assign busy       = busy_q;
    assign finish     = finish_q;
    assign error      = error_q;
    assign param_cs   = cs_q;
    assign param_oe   = cs_q;
    assign param_we   = 1'b0;
    assign param_addr = addr_q;
    assign M          = m_q;
    assign K          = k_q;
    assign N          = n_q;
    assign tile_start = tile_start_q;
    assign tile_m_idx = m_idx_q;
    assign tile_n_idx = n_idx_q;
    assign tile_m_sz  = m_sz_q;
    assign tile_n_sz  = n_sz_q;
    assign tiles_done = tiles_done_q;

endmodule
